// File: rtl/vscale_md_unit_pkg.sv
// Shared constants for the vscale RV32M multiply/divide unit: operand width,
// operation and output-select encodings, FSM state encodings, and a small
// two's-complement helper.
package vscale_md_unit_pkg;

    localparam int XPR_LEN          = 32;

    localparam int MD_OP_WIDTH      = 2;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL = 2'd0;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV = 2'd1;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM = 2'd2;

    localparam int MD_OUT_SEL_WIDTH = 1;
    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_LO = 1'b0;
    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_HI = 1'b1;

    localparam int MD_STATE_WIDTH   = 2;
    localparam logic [MD_STATE_WIDTH-1:0] MD_STATE_IDLE         = 2'd0;
    localparam logic [MD_STATE_WIDTH-1:0] MD_STATE_COMPUTE      = 2'd1;
    localparam logic [MD_STATE_WIDTH-1:0] MD_STATE_SETUP_OUTPUT = 2'd2;
    localparam logic [MD_STATE_WIDTH-1:0] MD_STATE_DONE         = 2'd3;

    // Two's-complement negation of a register-width value.
    function automatic logic [XPR_LEN-1:0] twos_neg(input logic [XPR_LEN-1:0] v);
        return (~v) + {{(XPR_LEN-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/vscale_md_unit.sv
// Iterative radix-2 multiply/divide unit for RV32M. Operands are reduced to
// magnitudes at accept, processed for 32 cycles in a shared 64-bit accumulator
// (shift-add for MUL, restoring shift-subtract for DIV/REM), then sign-fixed
// and presented with a one-cycle resp_valid strobe.
module vscale_md_unit
    import vscale_md_unit_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [MD_OP_WIDTH-1:0]      req_op,
    input  logic                        req_in_1_signed,
    input  logic                        req_in_2_signed,
    input  logic [MD_OUT_SEL_WIDTH-1:0] req_out_sel,
    input  logic [XPR_LEN-1:0]          req_in_1,
    input  logic [XPR_LEN-1:0]          req_in_2,
    input  logic                        kill,
    output logic                        resp_valid,
    output logic [XPR_LEN-1:0]          resp_result
);

    logic [MD_STATE_WIDTH-1:0]   state_q, state_d;
    logic [MD_OP_WIDTH-1:0]      op_q, op_d;
    logic [MD_OUT_SEL_WIDTH-1:0] out_sel_q, out_sel_d;
    logic                        negate_output_q, negate_output_d;
    logic [4:0]                  counter_q, counter_d;
    // Multiplicand for MUL, divisor for DIV/REM; constant during COMPUTE.
    logic [XPR_LEN-1:0]          operand_q, operand_d;
    // MUL: {partial product high, multiplier/low product}.
    // DIV: {remainder, dividend/quotient}.
    logic [2*XPR_LEN-1:0]        acc_q, acc_d;
    logic [XPR_LEN-1:0]          resp_result_q, resp_result_d;

    logic                        accept;
    logic                        sign_1, sign_2;
    logic [XPR_LEN-1:0]          abs_1, abs_2;
    logic [XPR_LEN:0]            mul_sum;
    logic [2*XPR_LEN-1:0]        mul_next;
    logic [XPR_LEN:0]            div_diff;
    logic [2*XPR_LEN-1:0]        div_next;
    logic [2*XPR_LEN-1:0]        product_signed;
    logic [XPR_LEN-1:0]          quotient, remainder;
    logic [XPR_LEN-1:0]          result_sel;

    assign req_ready   = (state_q == MD_STATE_IDLE);
    assign accept      = req_valid && req_ready && !kill;
    assign resp_valid  = (state_q == MD_STATE_DONE) && !kill;
    assign resp_result = resp_result_q;

    // Operand magnitudes and per-step datapath for multiply and divide.
    always_comb begin
        sign_1 = req_in_1_signed && req_in_1[XPR_LEN-1];
        sign_2 = req_in_2_signed && req_in_2[XPR_LEN-1];
        abs_1  = sign_1 ? twos_neg(req_in_1) : req_in_1;
        abs_2  = sign_2 ? twos_neg(req_in_2) : req_in_2;

        // Shift-add: add multiplicand into the high half when the current
        // multiplier bit is set, then shift the whole pair right by one.
        mul_sum  = {1'b0, acc_q[2*XPR_LEN-1:XPR_LEN]}
                 + (acc_q[0] ? {1'b0, operand_q} : {(XPR_LEN+1){1'b0}});
        mul_next = {mul_sum, acc_q[XPR_LEN-1:1]};

        // Restoring divide: trial-subtract the divisor from the shifted
        // remainder; the quotient bit is set when no borrow occurs.
        div_diff = acc_q[2*XPR_LEN-1:XPR_LEN-1] - {1'b0, operand_q};
        if (div_diff[XPR_LEN]) begin
            div_next = {acc_q[2*XPR_LEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XPR_LEN-1:0], acc_q[XPR_LEN-2:0], 1'b1};
        end
    end

    // Result selection and sign correction for SETUP_OUTPUT.
    always_comb begin
        // The full 64-bit product is negated so the HI half carries the
        // borrow from the LO half correctly.
        product_signed = negate_output_q ? ((~acc_q) + 64'd1) : acc_q;
        quotient       = acc_q[XPR_LEN-1:0];
        remainder      = acc_q[2*XPR_LEN-1:XPR_LEN];
        case (op_q)
            MD_OP_DIV: begin
                // Divide by zero yields all ones regardless of operand signs.
                if (negate_output_q && (operand_q != '0)) begin
                    result_sel = twos_neg(quotient);
                end else begin
                    result_sel = quotient;
                end
            end
            MD_OP_REM: result_sel = negate_output_q ? twos_neg(remainder) : remainder;
            default: begin
                if (out_sel_q == MD_OUT_HI) begin
                    result_sel = product_signed[2*XPR_LEN-1:XPR_LEN];
                end else begin
                    result_sel = product_signed[XPR_LEN-1:0];
                end
            end
        endcase
    end

    // Next-state logic for the FSM and all datapath registers.
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        out_sel_d       = out_sel_q;
        negate_output_d = negate_output_q;
        counter_d       = counter_q;
        operand_d       = operand_q;
        acc_d           = acc_q;
        resp_result_d   = resp_result_q;

        if (kill) begin
            state_d = MD_STATE_IDLE;
        end else begin
            case (state_q)
                MD_STATE_IDLE: begin
                    if (accept) begin
                        op_d      = req_op;
                        out_sel_d = req_out_sel;
                        counter_d = 5'd31;
                        state_d   = MD_STATE_COMPUTE;
                        if (req_op == MD_OP_REM) begin
                            negate_output_d = sign_1;
                        end else begin
                            negate_output_d = sign_1 ^ sign_2;
                        end
                        if (req_op == MD_OP_MUL) begin
                            operand_d = abs_1;
                            acc_d     = {{XPR_LEN{1'b0}}, abs_2};
                        end else begin
                            operand_d = abs_2;
                            acc_d     = {{XPR_LEN{1'b0}}, abs_1};
                        end
                    end
                end
                MD_STATE_COMPUTE: begin
                    acc_d     = (op_q == MD_OP_DIV || op_q == MD_OP_REM) ? div_next : mul_next;
                    counter_d = counter_q - 5'd1;
                    if (counter_q == 5'd0) begin
                        state_d = MD_STATE_SETUP_OUTPUT;
                    end
                end
                MD_STATE_SETUP_OUTPUT: begin
                    resp_result_d = result_sel;
                    state_d       = MD_STATE_DONE;
                end
                default: begin
                    state_d = MD_STATE_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= MD_STATE_IDLE;
            op_q            <= MD_OP_MUL;
            out_sel_q       <= MD_OUT_LO;
            negate_output_q <= 1'b0;
            counter_q       <= 5'd0;
            operand_q       <= '0;
            acc_q           <= '0;
            resp_result_q   <= '0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            out_sel_q       <= out_sel_d;
            negate_output_q <= negate_output_d;
            counter_q       <= counter_d;
            operand_q       <= operand_d;
            acc_q           <= acc_d;
            resp_result_q   <= resp_result_d;
        end
    end

endmodule

// File: tb/tb_vscale_md_unit.sv
// Directed testbench for vscale_md_unit: multiply, divide and remainder
// vectors with hand-computed results, plus kill and asynchronous reset cases.
module tb_vscale_md_unit;
    import vscale_md_unit_pkg::*;

    logic                        clk;
    logic                        reset_n;
    logic                        req_valid;
    logic                        req_ready;
    logic [MD_OP_WIDTH-1:0]      req_op;
    logic                        req_in_1_signed;
    logic                        req_in_2_signed;
    logic [MD_OUT_SEL_WIDTH-1:0] req_out_sel;
    logic [XPR_LEN-1:0]          req_in_1;
    logic [XPR_LEN-1:0]          req_in_2;
    logic                        kill;
    logic                        resp_valid;
    logic [XPR_LEN-1:0]          resp_result;

    int errors = 0;
    int checks = 0;
    logic flag;

    vscale_md_unit dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_in_1_signed (req_in_1_signed),
        .req_in_2_signed (req_in_2_signed),
        .req_out_sel     (req_out_sel),
        .req_in_1        (req_in_1),
        .req_in_2        (req_in_2),
        .kill            (kill),
        .resp_valid      (resp_valid),
        .resp_result     (resp_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge; returns at the negedge of cycle T+1.
    task automatic issue(input logic [1:0] op, input logic s1, input logic s2,
                         input logic sel, input logic [31:0] a, input logic [31:0] b);
        req_valid       = 1'b1;
        req_op          = op;
        req_in_1_signed = s1;
        req_in_2_signed = s2;
        req_out_sel     = sel;
        req_in_1        = a;
        req_in_2        = b;
        @(negedge clk);
        // Scramble fields after accept; the unit must ignore them.
        req_valid       = 1'b0;
        req_op          = MD_OP_REM;
        req_in_1_signed = ~s1;
        req_in_2_signed = ~s2;
        req_out_sel     = ~sel;
        req_in_1        = ~a;
        req_in_2        = ~b + 32'd3;
    endtask

    // Full transaction with latency, handshake and result checks.
    task automatic run_op(input string tag, input logic [1:0] op, input logic s1,
                          input logic s2, input logic sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        logic bad;
        bad = 1'b0;
        issue(op, s1, s2, sel, a, b);
        for (int k = 1; k <= 33; k++) begin
            if (req_ready !== 1'b0 || resp_valid !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        // Cycle T+34
        check({tag, "_busy"}, {31'd0, bad}, 32'd0);
        check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_ready_done"}, {31'd0, req_ready}, 32'd0);
        check({tag, "_result"}, resp_result, exp);
        @(negedge clk);
        // Cycle T+35
        check({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_valid_after"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_hold"}, resp_result, exp);
    endtask

    initial begin
        reset_n         = 1'b0;
        req_valid       = 1'b0;
        req_op          = MD_OP_MUL;
        req_in_1_signed = 1'b0;
        req_in_2_signed = 1'b0;
        req_out_sel     = MD_OUT_LO;
        req_in_1        = '0;
        req_in_2        = '0;
        kill            = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_valid", {31'd0, resp_valid}, 32'd0);
        check("reset_result", resp_result, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("mul_lo_u", MD_OP_MUL, 1'b0, 1'b0, MD_OUT_LO, 32'h0000_1234, 32'h0000_5678, 32'h0626_0060);
        run_op("mulh_ss", MD_OP_MUL, 1'b1, 1'b1, MD_OUT_HI, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulhu", MD_OP_MUL, 1'b0, 1'b0, MD_OUT_HI, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulh_neg", MD_OP_MUL, 1'b1, 1'b1, MD_OUT_HI, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF);
        run_op("mulhsu", MD_OP_MUL, 1'b1, 1'b0, MD_OUT_HI, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
        run_op("mul_lo_neg", MD_OP_MUL, 1'b1, 1'b1, MD_OUT_LO, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1);
        run_op("div_s", MD_OP_DIV, 1'b1, 1'b1, MD_OUT_LO, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
        run_op("rem_s", MD_OP_REM, 1'b1, 1'b1, MD_OUT_LO, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
        run_op("divu", MD_OP_DIV, 1'b0, 1'b0, MD_OUT_HI, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC);
        run_op("div_zero", MD_OP_DIV, 1'b1, 1'b1, MD_OUT_LO, 32'h8000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
        run_op("rem_zero", MD_OP_REM, 1'b1, 1'b1, MD_OUT_LO, 32'h8000_0005, 32'h0000_0000, 32'h8000_0005);
        run_op("div_ovf", MD_OP_DIV, 1'b1, 1'b1, MD_OUT_LO, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", MD_OP_REM, 1'b1, 1'b1, MD_OUT_LO, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

        // kill in IDLE alongside req_valid must block the accept
        req_valid = 1'b1;
        kill      = 1'b1;
        req_op    = MD_OP_MUL;
        req_in_1  = 32'd9;
        req_in_2  = 32'd9;
        @(negedge clk);
        req_valid = 1'b0;
        kill      = 1'b0;
        check("kill_idle_ready", {31'd0, req_ready}, 32'd1);

        // kill mid-COMPUTE at T+10
        issue(MD_OP_MUL, 1'b0, 1'b0, MD_OUT_LO, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        check("kill_mid_busy", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        kill = 1'b0;
        check("kill_mid_ready", {31'd0, req_ready}, 32'd1);
        flag = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (resp_valid !== 1'b0) flag = 1'b1;
            @(negedge clk);
        end
        check("kill_mid_no_valid", {31'd0, flag}, 32'd0);
        check("kill_mid_result_kept", resp_result, 32'h0000_0000);
        run_op("after_kill", MD_OP_MUL, 1'b0, 1'b0, MD_OUT_LO, 32'd7, 32'd6, 32'd42);

        // kill during DONE suppresses the strobe that cycle
        issue(MD_OP_DIV, 1'b0, 1'b0, MD_OUT_LO, 32'd100, 32'd7);
        repeat (33) @(negedge clk);
        check("done_state_busy", {31'd0, req_ready}, 32'd0);
        kill = 1'b1;
        #1;
        check("kill_done_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        kill = 1'b0;
        check("kill_done_ready", {31'd0, req_ready}, 32'd1);
        check("kill_done_valid_after", {31'd0, resp_valid}, 32'd0);

        // asynchronous reset mid-COMPUTE
        issue(MD_OP_MUL, 1'b0, 1'b0, MD_OUT_LO, 32'd11, 32'd13);
        repeat (5) @(negedge clk);
        check("pre_reset_busy", {31'd0, req_ready}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_ready", {31'd0, req_ready}, 32'd1);
        check("async_reset_valid", {31'd0, resp_valid}, 32'd0);
        check("async_reset_result", resp_result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_op("after_reset", MD_OP_REM, 1'b0, 1'b0, MD_OUT_LO, 32'd100, 32'd7, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
